// File: rtl/vec_mem_sequencer.sv
// Vector load/store sequencer. Walks LANES strided addresses, one lane per
// cycle. Stores drive latched lane data to the RAM. Loads gather the RAM read
// data, which returns RD_LAT cycles after each address, into a packed vector.
module vec_mem_sequencer #(
    parameter int LANES  = 16,
    parameter int ELEM_W = 16,
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    is_store,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       stride,
    input  logic [4:0]              rd_in,
    input  logic [LANES*ELEM_W-1:0] wdata_vec,
    input  logic [ELEM_W-1:0]       mem_rdata,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [ELEM_W-1:0]       mem_wdata,
    output logic                    mem_we,
    output logic                    busy,
    output logic                    stall,
    output logic                    done,
    output logic [LANES*ELEM_W-1:0] rdata_vec,
    output logic [4:0]              rd_out,
    output logic [CNT_W-1:0]        mem_cycles
);
    localparam int            LW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    state_e            state_q;
    logic [LW-1:0]     lane_q;
    logic [LW-1:0]     lane_nxt;
    logic              is_store_q;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ELEM_W-1:0] mem_wdata_q;
    logic              mem_we_q;
    logic              done_q;
    logic [4:0]        rd_q;
    logic [CNT_W-1:0]  cycles_q;
    logic [ELEM_W-1:0] wdata_q    [LANES];
    logic [ELEM_W-1:0] rdata_q    [LANES];
    logic              cap_vld_q  [RD_LAT];
    logic [LW-1:0]     cap_lane_q [RD_LAT];
    logic              idle;
    logic              accept;
    logic              cap_fire;
    logic              cap_last;

    assign idle     = (state_q == S_IDLE);
    assign accept   = idle && start;
    assign lane_nxt = lane_q + LW'(1);
    assign cap_fire = cap_vld_q[RD_LAT-1];
    assign cap_last = cap_fire && (cap_lane_q[RD_LAT-1] == LAST_LANE);

    assign busy       = !idle;
    // Gated by rst so the freeze request is low throughout reset even if start is high.
    assign stall      = rst && (busy || (start && idle));
    assign done       = done_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign rd_out     = rd_q;
    assign mem_cycles = cycles_q;

    // Sequencer FSM: accepts a request, issues one lane per cycle, drains loads, pulses done.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state_q     <= S_IDLE;
            lane_q      <= '0;
            is_store_q  <= 1'b0;
            stride_q    <= '0;
            rd_q        <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_ISSUE;
                        lane_q     <= '0;
                        is_store_q <= is_store;
                        stride_q   <= stride;
                        rd_q       <= rd_in;
                        mem_addr_q <= base_addr;
                        mem_we_q   <= is_store;
                        if (is_store) mem_wdata_q <= wdata_vec[ELEM_W-1:0];
                    end
                end
                S_ISSUE: begin
                    if (lane_q == LAST_LANE) begin
                        mem_we_q <= 1'b0;
                        if (is_store_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end else begin
                        lane_q     <= lane_nxt;
                        mem_addr_q <= mem_addr_q + stride_q;
                        if (is_store_q) mem_wdata_q <= wdata_q[lane_nxt];
                    end
                end
                S_DRAIN: begin
                    if (cap_last) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Store payload, captured on an accepted start.
    // NOTE: pure data storage with no reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < LANES; k++) wdata_q[k] <= wdata_vec[k*ELEM_W +: ELEM_W];
        end
    end

    // Read-return tracker. Its last stage is valid in the cycle where lane data sits on mem_rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                cap_vld_q[i]  <= 1'b0;
                cap_lane_q[i] <= '0;
            end
        end else begin
            cap_vld_q[0]  <= (state_q == S_ISSUE) && !is_store_q;
            cap_lane_q[0] <= lane_q;
            for (int i = 1; i < RD_LAT; i++) begin
                cap_vld_q[i]  <= cap_vld_q[i-1];
                cap_lane_q[i] <= cap_lane_q[i-1];
            end
        end
    end

    // Load vector assembly. Lanes change only on a capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LANES; k++) rdata_q[k] <= '0;
        end else if (cap_fire) begin
            rdata_q[cap_lane_q[RD_LAT-1]] <= mem_rdata;
        end
    end

    // Saturating count of busy cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles_q <= '0;
        end else if (busy && (cycles_q != {CNT_W{1'b1}})) begin
            cycles_q <= cycles_q + CNT_W'(1);
        end
    end

    // Pack the lane registers onto the output vector.
    always_comb begin
        // NOTE: a default assignment first keeps always_comb free of inferred latches.
        rdata_vec = '0;
        for (int k = 0; k < LANES; k++) rdata_vec[k*ELEM_W +: ELEM_W] = rdata_q[k];
    end
endmodule
